// File: rtl/sme_pkg.sv
// Shared widths, FSM encoding and helpers for the masked S-box sequencers.
package sme_pkg;

    localparam int SBOX_MID_IN_W  = 21;
    localparam int SBOX_MID_OUT_W = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        OUT   = 2'd2,
        FLUSH = 2'd3
    } sbox_inv_seq_state_t;

    // Number of fresh random bits consumed by a DOM AND layer of the given size.
    function automatic int sme_rng_width(input int smax, input int gates);
        return gates * smax * (smax - 1) / 2;
    endfunction

endpackage

// File: rtl/sme_sbox_inv_seq.sv
// Sequencer for the masked inverse-S-box middle layer: binds one randomness
// word to one input set, runs the layer for LAT enabled cycles, holds the
// result for the consumer and then wipes every share-bearing register.
module sme_sbox_inv_seq
    import sme_pkg::*;
#(
    parameter int SMAX      = 2,
    parameter int LAT       = 4,
    parameter int AND_GATES = 34,
    localparam int RW       = sme_rng_width(SMAX, AND_GATES) - 1,
    localparam int XW       = SMAX * SBOX_MID_IN_W,
    localparam int YW       = SMAX * SBOX_MID_OUT_W
) (
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    input  logic          rng_valid,
    output logic          rng_ready,
    input  logic [RW:0]   rng_in,
    output logic          mid_en,
    output logic          mid_flush,
    output logic [RW:0]   mid_rng,
    output logic [XW-1:0] mid_x,
    input  logic [YW-1:0] mid_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [YW-1:0] out_y
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    sbox_inv_seq_state_t state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [XW-1:0]       x_reg, x_next;
    logic [RW:0]         r_reg, r_next;
    logic [YW-1:0]       y_reg, y_next;

    // Next-state, counter and share-register update. Inputs and randomness are
    // wiped as soon as the result is captured, and the result is wiped on
    // acceptance, so neither is visible in FLUSH or IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        x_next     = x_reg;
        r_next     = r_reg;
        y_next     = y_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && rng_valid) begin
                    x_next     = in_x;
                    r_next     = rng_in;
                    cnt_next   = CW'(LAT - 1);
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == '0) begin
                    y_next     = mid_y;
                    x_next     = '0;
                    r_next     = '0;
                    state_next = OUT;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    y_next     = '0;
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                x_next     = '0;
                r_next     = '0;
                y_next     = '0;
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                x_next     = '0;
                r_next     = '0;
                y_next     = '0;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State, counter and randomness registers.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            r_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            r_reg     <= r_next;
        end
    end

    // Per-share input and result holding registers.
    for (genvar gi = 0; gi < SMAX; gi++) begin : g_share
        always_ff @(posedge g_clk) begin
            if (g_reset) begin
                x_reg[gi*SBOX_MID_IN_W +: SBOX_MID_IN_W]   <= '0;
                y_reg[gi*SBOX_MID_OUT_W +: SBOX_MID_OUT_W] <= '0;
            end else begin
                x_reg[gi*SBOX_MID_IN_W +: SBOX_MID_IN_W]   <= x_next[gi*SBOX_MID_IN_W +: SBOX_MID_IN_W];
                y_reg[gi*SBOX_MID_OUT_W +: SBOX_MID_OUT_W] <= y_next[gi*SBOX_MID_OUT_W +: SBOX_MID_OUT_W];
            end
        end
    end

    // Handshakes and layer controls decode from state; share data comes
    // straight from registers with no combinational path from the inputs.
    assign in_ready  = (state_reg == IDLE) && rng_valid;
    assign rng_ready = (state_reg == IDLE) && rng_valid && in_valid;
    assign mid_en    = (state_reg == RUN);
    assign mid_flush = (state_reg == FLUSH);
    assign out_valid = (state_reg == OUT);
    assign mid_x     = x_reg;
    assign mid_rng   = r_reg;
    assign out_y     = y_reg;

endmodule

// File: tb/tb_sme_sbox_inv_seq.sv
// Directed bench for the inverse-S-box middle-layer sequencer (SMAX=2, LAT=4).
module tb_sme_sbox_inv_seq;

    localparam int SMAX = 2;
    localparam int LAT  = 4;
    localparam int RW   = 33;
    localparam int XW   = 42;
    localparam int YW   = 36;

    localparam logic [XW-1:0] X1 = {21'h0ABCDE, 21'h154321};
    localparam logic [XW-1:0] X2 = {21'h1FFFFF, 21'h000001};
    localparam logic [RW:0]   R1 = 34'h2DEADBEEF;
    localparam logic [RW:0]   R2 = 34'h1CAFEF00D;
    localparam logic [YW-1:0] YA = 36'h123456789;
    localparam logic [YW-1:0] YB = 36'hFEDCBA987;
    localparam logic [YW-1:0] YC = 36'h0F0F0F0F0;
    localparam logic [YW-1:0] YD = 36'hA5A5A5A5A;

    logic          g_clk = 1'b0;
    logic          g_reset;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic          rng_valid;
    logic          rng_ready;
    logic [RW:0]   rng_in;
    logic          mid_en;
    logic          mid_flush;
    logic [RW:0]   mid_rng;
    logic [XW-1:0] mid_x;
    logic [YW-1:0] mid_y;
    logic          out_valid;
    logic          out_ready;
    logic [YW-1:0] out_y;

    int checks = 0;
    int errors = 0;

    sme_sbox_inv_seq #(.SMAX(SMAX), .LAT(LAT), .AND_GATES(34)) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .rng_valid (rng_valid),
        .rng_ready (rng_ready),
        .rng_in    (rng_in),
        .mid_en    (mid_en),
        .mid_flush (mid_flush),
        .mid_rng   (mid_rng),
        .mid_x     (mid_x),
        .mid_y     (mid_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven and
    // outputs sampled there, well away from the edge.
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_reset   = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        rng_valid = 1'b0;
        rng_in    = '0;
        mid_y     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        g_reset = 1'b0;
        #1;
        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_en", 64'(mid_en), 64'd0);
        check("rst_mid_flush", 64'(mid_flush), 64'd0);
        check("rst_mid_x", 64'(mid_x), 64'd0);
        check("rst_mid_rng", 64'(mid_rng), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_in_ready_lo", 64'(in_ready), 64'd0);
        rng_valid = 1'b1;
        #1;
        check("rst_in_ready_hi", 64'(in_ready), 64'd1);

        // 1. Basic operation
        in_valid = 1'b1; in_x = X1; rng_in = R1; out_ready = 1'b1;
        #1;
        check("t1_hs_rng_ready", 64'(rng_ready), 64'd1);
        tick();
        in_valid = 1'b0; in_x = X2; rng_in = R2;
        for (int i = 1; i <= LAT; i++) begin
            mid_y = (i == LAT) ? YB : YA;
            #1;
            check($sformatf("t1_run%0d_mid_en", i), 64'(mid_en), 64'd1);
            check($sformatf("t1_run%0d_mid_x", i), 64'(mid_x), 64'(X1));
            check($sformatf("t1_run%0d_mid_rng", i), 64'(mid_rng), 64'(R1));
            check($sformatf("t1_run%0d_in_ready", i), 64'(in_ready), 64'd0);
            tick();
        end
        mid_y = YA;
        #1;
        check("t1_t5_out_valid", 64'(out_valid), 64'd1);
        check("t1_t5_out_y", 64'(out_y), 64'(YB));
        check("t1_t5_mid_en", 64'(mid_en), 64'd0);
        check("t1_t5_mid_x", 64'(mid_x), 64'd0);
        tick();
        check("t1_t6_mid_flush", 64'(mid_flush), 64'd1);
        check("t1_t6_out_y", 64'(out_y), 64'd0);
        check("t1_t6_mid_x", 64'(mid_x), 64'd0);
        check("t1_t6_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("t1_t7_in_ready", 64'(in_ready), 64'd1);
        check("t1_t7_mid_flush", 64'(mid_flush), 64'd0);

        // 2. Randomness starvation
        rng_valid = 1'b0; in_valid = 1'b1; in_x = X2; rng_in = R2;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("t2_starve%0d_in_ready", i), 64'(in_ready), 64'd0);
            check($sformatf("t2_starve%0d_mid_en", i), 64'(mid_en), 64'd0);
            tick();
        end
        rng_valid = 1'b1;
        #1;
        check("t2_hs_rng_ready", 64'(rng_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("t2_run_rng_ready", 64'(rng_ready), 64'd0);
        check("t2_run_mid_x", 64'(mid_x), 64'(X2));
        mid_y = YC;
        out_ready = 1'b0;
        repeat (LAT) tick();

        // 3. Output back-pressure
        for (int i = 0; i < 20; i++) begin
            mid_y = (i % 2 == 0) ? YA : YB;
            #1;
            check($sformatf("t3_hold%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("t3_hold%0d_out_y", i), 64'(out_y), 64'(YC));
            check($sformatf("t3_hold%0d_mid_en", i), 64'(mid_en), 64'd0);
            check($sformatf("t3_hold%0d_in_ready", i), 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t3_flush", 64'(mid_flush), 64'd1);
        check("t3_flush_out_valid", 64'(out_valid), 64'd0);
        tick();

        // 4. Reset mid-RUN
        in_valid = 1'b1; in_x = X1; rng_in = R1;
        tick();
        in_valid = 1'b0;
        tick();
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        #1;
        check("t4_t3_mid_en", 64'(mid_en), 64'd0);
        check("t4_t3_mid_x", 64'(mid_x), 64'd0);
        check("t4_t3_mid_rng", 64'(mid_rng), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_after%0d_out_valid", i), 64'(out_valid), 64'd0);
            tick();
        end

        // 5. Back-to-back throughput
        in_valid = 1'b1; in_x = X2; rng_in = R2; mid_y = YD; out_ready = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            #1;
            check($sformatf("t5_c%0d_out_valid", c), 64'(out_valid),
                  64'((c == 5) || (c == 12) || (c == 19)));
            if ((c % 7 == 0) || (c % 7 == 6)) begin
                check($sformatf("t5_c%0d_idle_mid_x", c), 64'(mid_x), 64'd0);
                check($sformatf("t5_c%0d_idle_out_y", c), 64'(out_y), 64'd0);
            end else if (c % 7 == 5) begin
                check($sformatf("t5_c%0d_out_y", c), 64'(out_y), 64'(YD));
            end else begin
                check($sformatf("t5_c%0d_run_mid_x", c), 64'(mid_x), 64'(X2));
            end
            tick();
        end
        in_valid = 1'b0;

        // 6. Ignored stray input
        in_valid = 1'b1; in_x = X1; rng_in = R1; mid_y = YA;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_x = X2; rng_in = R2;
        #1;
        check("t6_stray_rng_ready", 64'(rng_ready), 64'd0);
        check("t6_stray_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("t6_t3_mid_x", 64'(mid_x), 64'(X1));
        check("t6_t3_mid_rng", 64'(mid_rng), 64'(R1));
        in_valid = 1'b0;
        tick();
        mid_y = YB;
        tick();
        mid_y = YA;
        #1;
        check("t6_t5_out_valid", 64'(out_valid), 64'd1);
        check("t6_t5_out_y", 64'(out_y), 64'(YB));
        tick();
        check("t6_t6_flush", 64'(mid_flush), 64'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
